// File: rtl/pwm_speed_decoder_pkg.sv
// Constants shared by the fan PWM generator and the PWM speed decoder.
package pwm_speed_decoder_pkg;

    localparam int PWM_PERIOD_W      = 8;
    localparam int PWM_SYNC_STAGES   = 2;
    localparam int PWM_TIMEOUT_EXTRA = 4;

    // Decoder FSM encoding; kept as plain constants so legacy blocks can share it.
    localparam logic [1:0] ST_WAIT_RISE       = 2'd0;
    localparam logic [1:0] ST_HIGH            = 2'd1;
    localparam logic [1:0] ST_LOW             = 2'd2;
    localparam logic [1:0] ST_WAIT_FALL_STUCK = 2'd3;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM line and produces rise/fall strobes.
// Build macro DEGLITCH_EN: a level change must persist for 2 samples before it is accepted.
module pwm_edge_sync
    import pwm_speed_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_arst,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level_d;
    logic                   w_level;

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
        end
    end

`ifdef DEGLITCH_EN
    logic r_filt;

    // The last two stages agreeing means the new level has been seen on two samples.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_filt <= 1'b0;
        end else if (r_sync[SYNC_STAGES-1] == r_sync[SYNC_STAGES-2]) begin
            r_filt <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_level_d;
    assign o_fall  = ~w_level & r_level_d;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Recovers the fan speed code from a PWM line by timing high/low phases of each period.
// Build macro DEGLITCH_EN (in pwm_edge_sync) rejects single-cycle pulses on pwm_in.
module pwm_speed_decoder
    import pwm_speed_decoder_pkg::*;
#(
    parameter int PERIOD_W      = PWM_PERIOD_W,
    parameter int SYNC_STAGES   = PWM_SYNC_STAGES,
    parameter int TIMEOUT_EXTRA = PWM_TIMEOUT_EXTRA
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                pwm_in,
    output logic [PERIOD_W-1:0] speed_out,
    output logic                speed_valid,
    output logic                period_err,
    output logic                stuck_low,
    output logic                stuck_high
);

    localparam int CNT_W = PERIOD_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'((1 << PERIOD_W) + TIMEOUT_EXTRA);
    localparam logic [SUM_W-1:0] PERIOD_CNT  = SUM_W'(1 << PERIOD_W);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_high;
    logic [CNT_W-1:0]    r_low;
    logic [CNT_W-1:0]    r_run;
    logic                r_skip;
    logic [PERIOD_W-1:0] r_speed;
    logic                r_valid_pend;
    logic                r_valid;
    logic                r_err_pend;
    logic                r_err;
    logic                r_stuck_low;
    logic                r_stuck_high;

    logic                w_level;
    logic                w_rise;
    logic                w_fall;
    logic [CNT_W-1:0]    w_run_now;
    logic [CNT_W-1:0]    w_high_inc;
    logic [CNT_W-1:0]    w_low_inc;
    logic [SUM_W-1:0]    w_sum;
    logic                w_timeout_high;
    logic                w_timeout_low;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .i_clk  (clk),
        .i_arst (arst),
        .i_pwm  (pwm_in),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Length of the current constant-level run, including this cycle; restarts on any edge.
    assign w_run_now  = (w_rise | w_fall) ? CNT_ONE : ((r_run == CNT_MAX) ? r_run : r_run + 1'b1);
    assign w_high_inc = (r_high == CNT_MAX) ? r_high : r_high + 1'b1;
    assign w_low_inc  = (r_low == CNT_MAX) ? r_low : r_low + 1'b1;
    assign w_sum      = {1'b0, r_high} + {1'b0, r_low};

    assign w_timeout_high = w_level & ~w_rise & (w_run_now == TIMEOUT_CNT);
    assign w_timeout_low  = ~w_level & ~w_fall & (w_run_now == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state      <= ST_WAIT_RISE;
            r_high       <= '0;
            r_low        <= '0;
            r_run        <= '0;
            r_skip       <= 1'b0;
            r_speed      <= '0;
            r_valid_pend <= 1'b0;
            r_valid      <= 1'b0;
            r_err_pend   <= 1'b0;
            r_err        <= 1'b0;
            r_stuck_low  <= 1'b0;
            r_stuck_high <= 1'b0;
        end else begin
            r_run        <= w_run_now;
            r_valid_pend <= 1'b0;
            r_err_pend   <= 1'b0;
            r_valid      <= r_valid_pend;
            r_err        <= r_err_pend;

            if (w_rise) begin
                r_stuck_low <= 1'b0;
            end
            if (w_fall) begin
                r_stuck_high <= 1'b0;
            end

            case (r_state)
                ST_WAIT_RISE: begin
                    r_high <= '0;
                    r_low  <= '0;
                    if (w_rise) begin
                        r_state <= ST_HIGH;
                        r_high  <= CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        r_state <= ST_LOW;
                        r_low   <= CNT_ONE;
                    end else if (w_level) begin
                        r_high <= w_high_inc;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        // The closing rise of one period also opens the next one.
                        if (!r_skip) begin
                            if (w_sum == PERIOD_CNT) begin
                                r_speed      <= r_high[PERIOD_W-1:0];
                                r_valid_pend <= 1'b1;
                            end else begin
                                r_err_pend <= 1'b1;
                            end
                        end
                        r_skip  <= 1'b0;
                        r_state <= ST_HIGH;
                        r_high  <= CNT_ONE;
                        r_low   <= '0;
                    end else if (!w_level) begin
                        r_low <= w_low_inc;
                    end
                end
                default: begin
                    r_high <= '0;
                    r_low  <= '0;
                    if (w_fall) begin
                        r_state <= ST_LOW;
                        r_low   <= CNT_ONE;
                    end
                end
            endcase

            // A stuck line overrides the measurement; after stuck-high the partial period is skipped.
            if (w_timeout_high) begin
                r_stuck_high <= 1'b1;
                r_speed      <= '1;
                r_valid_pend <= 1'b1;
                r_state      <= ST_WAIT_FALL_STUCK;
                r_high       <= '0;
                r_low        <= '0;
                r_skip       <= 1'b1;
            end else if (w_timeout_low) begin
                r_stuck_low  <= 1'b1;
                r_speed      <= '0;
                r_valid_pend <= 1'b1;
                r_state      <= ST_WAIT_RISE;
                r_high       <= '0;
                r_low        <= '0;
                r_skip       <= 1'b0;
            end
        end
    end

    assign speed_out   = r_speed;
    assign speed_valid = r_valid;
    assign period_err  = r_err;
    assign stuck_low   = r_stuck_low;
    assign stuck_high  = r_stuck_high;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Self-checking bench for pwm_speed_decoder: PWM periods in, period-level reference model out.
module tb_pwm_speed_decoder;

    localparam int PERIOD_W      = 8;
    localparam int SYNC_STAGES   = 2;
    localparam int TIMEOUT_EXTRA = 4;
    localparam int NOMINAL       = 1 << PERIOD_W;
    localparam int TIMEOUT       = NOMINAL + TIMEOUT_EXTRA;
`ifdef DEGLITCH_EN
    localparam int DG = 1;
`else
    localparam int DG = 0;
`endif
    localparam int LATENCY = SYNC_STAGES + 2 + DG;

    logic                clk = 1'b0;
    logic                arst;
    logic                pwm_in;
    logic [PERIOD_W-1:0] speed_out;
    logic                speed_valid;
    logic                period_err;
    logic                stuck_low;
    logic                stuck_high;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   validCodes[$];
    int   validCycles[$];
    int   errCount       = 0;
    int   stuckLowCycle  = -1;
    int   stuckHighCycle = -1;
    logic prevStuckLow   = 1'b0;
    logic prevStuckHigh  = 1'b0;

    int expCodes[$];
    int expCycles[$];
    int expErrs       = 0;
    int lastCode      = 0;
    bit havePending   = 1'b0;
    int pendHigh      = 0;
    int pendLen       = 0;
    int lastFallCycle = 0;

    pwm_speed_decoder #(
        .PERIOD_W     (PERIOD_W),
        .SYNC_STAGES  (SYNC_STAGES),
        .TIMEOUT_EXTRA(TIMEOUT_EXTRA)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .pwm_in     (pwm_in),
        .speed_out  (speed_out),
        .speed_valid(speed_valid),
        .period_err (period_err),
        .stuck_low  (stuck_low),
        .stuck_high (stuck_high)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output event with the cycle it was seen in.
    always @(negedge clk) begin
        if (speed_valid) begin
            validCodes.push_back(int'(speed_out));
            validCycles.push_back(cyc);
        end
        if (period_err) errCount++;
        if (stuck_low && !prevStuckLow) stuckLowCycle = cyc;
        if (stuck_high && !prevStuckHigh) stuckHighCycle = cyc;
        prevStuckLow  = stuck_low;
        prevStuckHigh = stuck_high;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int n);
        pwm_in = level;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A rising edge closes the pending period: valid if it spanned exactly NOMINAL cycles.
    task automatic modelRise(input int riseCycle);
        if (havePending) begin
            if (pendLen == NOMINAL) begin
                expCodes.push_back(pendHigh);
                expCycles.push_back(riseCycle + LATENCY);
                lastCode = pendHigh;
            end else begin
                expErrs++;
            end
        end
        havePending = 1'b0;
    endtask

    task automatic modelStuck(input int code);
        expCodes.push_back(code);
        expCycles.push_back(-1);
        lastCode    = code;
        havePending = 1'b0;
    endtask

    task automatic drivePeriod(input int high, input int len);
        modelRise(cyc);
        pendHigh    = high;
        pendLen     = len;
        havePending = 1'b1;
        applyStimulus(1'b1, high);
        lastFallCycle = cyc;
        applyStimulus(1'b0, len - high);
    endtask

    task automatic checkEvents(input string tag);
        checkOutput({tag, "_nvalid"}, 32'(validCodes.size()), 32'(expCodes.size()));
        for (int i = 0; i < expCodes.size(); i++) begin
            if (i < validCodes.size()) begin
                checkOutput({tag, "_code"}, 32'(validCodes[i]), 32'(expCodes[i]));
                if (expCycles[i] >= 0)
                    checkOutput({tag, "_latency"}, 32'(validCycles[i]), 32'(expCycles[i]));
            end
        end
        checkOutput({tag, "_nerr"}, 32'(errCount), 32'(expErrs));
        checkOutput({tag, "_speed_out"}, 32'(speed_out), 32'(lastCode));
        validCodes.delete();
        validCycles.delete();
        expCodes.delete();
        expCycles.delete();
        errCount = 0;
        expErrs  = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_speed_out"}, 32'(speed_out), 32'(0));
        checkOutput({tag, "_speed_valid"}, 32'(speed_valid), 32'(0));
        checkOutput({tag, "_period_err"}, 32'(period_err), 32'(0));
        checkOutput({tag, "_stuck_low"}, 32'(stuck_low), 32'(0));
        checkOutput({tag, "_stuck_high"}, 32'(stuck_high), 32'(0));
    endtask

    initial begin
        int high;
        int len;
        int hiMax;
        int riseCycle;

        arst   = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        checkResetState("reset");

        for (int i = 0; i < 6; i++) drivePeriod(64, NOMINAL);
        checkEvents("steady64");

        for (int i = 0; i < 3; i++) drivePeriod(200, NOMINAL);
        checkEvents("change200");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                len = int'($urandom_range(200, 259));
                if (len == NOMINAL) len = 250;
            end else begin
                len = NOMINAL;
            end
            hiMax = (len - 1 > 255) ? 255 : len - 1;
            high  = int'($urandom_range(1, hiMax));
            drivePeriod(high, len);
        end
        checkEvents("random");

        drivePeriod(100, 250);
        drivePeriod(77, NOMINAL);
        checkEvents("err250");

        stuckLowCycle = -1;
        applyStimulus(1'b0, 300);
        modelStuck(0);
        checkOutput("stuck_low_level", 32'(stuck_low), 32'(1));
        checkOutput("stuck_low_other", 32'(stuck_high), 32'(0));
        checkOutput("stuck_low_time", 32'((stuckLowCycle - lastFallCycle >= TIMEOUT) &&
                                          (stuckLowCycle - lastFallCycle <= TIMEOUT + LATENCY)), 32'(1));
        checkEvents("stuckLow");

        for (int i = 0; i < 4; i++) drivePeriod(10, NOMINAL);
        checkOutput("stuck_low_cleared", 32'(stuck_low), 32'(0));
        checkEvents("resume10");

        riseCycle      = cyc;
        stuckHighCycle = -1;
        modelRise(riseCycle);
        applyStimulus(1'b1, 300);
        modelStuck(255);
        checkOutput("stuck_high_level", 32'(stuck_high), 32'(1));
        checkOutput("stuck_high_time", 32'((stuckHighCycle - riseCycle >= TIMEOUT) &&
                                           (stuckHighCycle - riseCycle <= TIMEOUT + LATENCY)), 32'(1));
        checkEvents("stuckHigh");

        applyStimulus(1'b0, NOMINAL - 128);
        checkOutput("stuck_high_cleared", 32'(stuck_high), 32'(0));
        for (int i = 0; i < 4; i++) drivePeriod(128, NOMINAL);
        checkEvents("resume128");

        modelRise(cyc);
        applyStimulus(1'b1, 50);
        checkEvents("preReset");
        arst   = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        arst     = 1'b0;
        lastCode = 0;
        checkResetState("midReset");
        applyStimulus(1'b0, 150);
        for (int i = 0; i < 3; i++) drivePeriod(200, NOMINAL);
        checkEvents("afterReset");

`ifdef DEGLITCH_EN
        for (int i = 0; i < 4; i++) begin
            modelRise(cyc);
            pendHigh    = 90;
            pendLen     = NOMINAL;
            havePending = 1'b1;
            applyStimulus(1'b1, 90);
            applyStimulus(1'b0, 40);
            applyStimulus(1'b1, 1);
            applyStimulus(1'b0, NOMINAL - 90 - 41);
        end
        checkEvents("deglitch");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
